// File: rtl/video_fetch_rbuf.sv
// video_fetch_rbuf: scanline read fetcher with an NTAG-slot reorder buffer; returns beats in address order.
// Latency: request issues 1 cycle after line_start; beat is presented 1 cycle after its ack at the earliest.
// Backpressure: dat_rdy low holds the head beat; issue stops once all NTAG slots are busy; resp.stall holds the request.
//
// Ports:
//   clk, rst (async, active-low)                    clock / reset
//   line_start, base_adr[31:0], nbeats[11:0]        scanline fetch command
//   req  (fta_cmd_request128_t)                     read request: cyc/stb/we/sel/tid/adr
//   resp (fta_cmd_response128_t)                    memory response: ack/stall/tid/dat
//   dat_o[127:0], dat_vld, dat_rdy                  in-order beat stream
//   busy, line_done (pulse), overrun, bad_tid (sticky) status
//   timeout (sticky)                                only when VIDEO_FETCH_TIMEOUT_EN is defined
//
// Optional feature: define VIDEO_FETCH_TIMEOUT_EN to add per-slot age counters. A slot that
// waits 255 cycles for its ack is filled with 128'hDEADBEEF... and the sticky timeout output is set.

package fta_pkg;
    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [15:0] sel;
        logic [7:0]  tid;
        logic [31:0] adr;
    } fta_cmd_request128_t;

    typedef struct packed {
        logic         ack;
        logic         stall;
        logic [7:0]   tid;
        logic [127:0] dat;
    } fta_cmd_response128_t;
endpackage

module video_fetch_rbuf
    import fta_pkg::*;
#(
    parameter int NTAG       = 8,
    parameter int BEAT_BYTES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 line_start,
    input  logic [31:0]          base_adr,
    input  logic [11:0]          nbeats,
    output fta_cmd_request128_t  req,
    input  fta_cmd_response128_t resp,
    output logic [127:0]         dat_o,
    output logic                 dat_vld,
    input  logic                 dat_rdy,
    output logic                 busy,
    output logic                 line_done,
    output logic                 overrun,
    output logic                 bad_tid
`ifdef VIDEO_FETCH_TIMEOUT_EN
    ,
    output logic                 timeout
`endif
);

    localparam int PW = $clog2(NTAG);
    typedef logic [PW-1:0] ptr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            done_nxt;

    logic [31:0]     base_q;
    logic [11:0]     nbeats_q;
    logic [11:0]     issue_cnt;
    logic [11:0]     retire_cnt;
    ptr_t            iptr;
    ptr_t            hptr;
    // slot_busy: issued and not yet consumed; slot_fill: data has arrived.
    // A slot is in flight when busy and not filled.
    logic [NTAG-1:0] slot_busy;
    logic [NTAG-1:0] slot_fill;
    logic [127:0]    slot_dat [NTAG];

    logic            consume;
    logic            iptr_free;
    logic            issue_pend;
    logic            issue;
    logic            start_fetch;
    ptr_t            ack_idx;
    logic            ack_ok;
    logic            ack_bad;

    assign dat_vld = slot_fill[hptr];
    assign dat_o   = slot_dat[hptr];
    assign consume = dat_vld && dat_rdy;
    assign busy    = (state != IDLE);

    // The head slot being consumed this cycle may be handed straight back to the issue side.
    assign iptr_free   = !slot_busy[iptr] || (consume && (hptr == iptr));
    assign issue_pend  = (state == FETCH) && (issue_cnt != nbeats_q) && iptr_free;
    assign issue       = issue_pend && !resp.stall;
    assign start_fetch = (state == IDLE) && line_start && (nbeats != 12'd0);

    // Tags carry the slot index in the low bits; any upper bit set can't belong to us.
    assign ack_idx = resp.tid[PW-1:0];
    assign ack_ok  = resp.ack && (resp.tid[7:PW] == '0) &&
                     slot_busy[ack_idx] && !slot_fill[ack_idx];
    assign ack_bad = resp.ack && !ack_ok;

    // Request fields are pure functions of held state, so they stay put while stalled.
    always_comb begin
        req     = '0;
        req.cyc = issue_pend;
        req.stb = issue_pend;
        req.we  = 1'b0;
        req.sel = '1;
        req.tid = 8'(iptr);
        req.adr = base_q + 32'(issue_cnt) * 32'(BEAT_BYTES);
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            line_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            line_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (line_start) begin
                    if (nbeats != 12'd0) state_nxt = FETCH;
                    else                 done_nxt  = 1'b1;
                end
            end
            FETCH: begin
                if (issue_cnt == nbeats_q) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (retire_cnt == nbeats_q) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef VIDEO_FETCH_TIMEOUT_EN
    logic [7:0]      age [NTAG];
    logic [NTAG-1:0] to_fire;
    logic            timeout_q;

    assign timeout = timeout_q;

    // An ack landing in the same cycle wins over the timeout fill.
    always_comb begin
        to_fire = '0;
        for (int k = 0; k < NTAG; k++) begin
            to_fire[k] = slot_busy[k] && !slot_fill[k] && (age[k] == 8'd254) &&
                         !(ack_ok && (ack_idx == ptr_t'(k)));
        end
    end
`endif

    // ---------------- slot bookkeeping ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q     <= '0;
            nbeats_q   <= '0;
            issue_cnt  <= '0;
            retire_cnt <= '0;
            iptr       <= '0;
            hptr       <= '0;
            slot_busy  <= '0;
            slot_fill  <= '0;
            overrun    <= 1'b0;
            bad_tid    <= 1'b0;
`ifdef VIDEO_FETCH_TIMEOUT_EN
            timeout_q  <= 1'b0;
            for (int k = 0; k < NTAG; k++) age[k] <= '0;
`endif
        end else begin
            if (consume) begin
                slot_busy[hptr] <= 1'b0;
                slot_fill[hptr] <= 1'b0;
                hptr            <= hptr + 1'b1;
                retire_cnt      <= retire_cnt + 12'd1;
            end
            if (ack_ok) begin
                slot_fill[ack_idx] <= 1'b1;
            end
            // Placed after the consume clear so a same-cycle reissue of the head slot sticks.
            if (issue) begin
                slot_busy[iptr] <= 1'b1;
                iptr            <= iptr + 1'b1;
                issue_cnt       <= issue_cnt + 12'd1;
            end
            if (start_fetch) begin
                base_q     <= base_adr;
                nbeats_q   <= nbeats;
                issue_cnt  <= '0;
                retire_cnt <= '0;
            end
            if (line_start && (state != IDLE)) overrun <= 1'b1;
            if (ack_bad)                       bad_tid <= 1'b1;
`ifdef VIDEO_FETCH_TIMEOUT_EN
            for (int k = 0; k < NTAG; k++) begin
                if (issue && (iptr == ptr_t'(k))) begin
                    age[k] <= '0;
                end else if (slot_busy[k] && !slot_fill[k]) begin
                    age[k] <= age[k] + 8'd1;
                end
                if (to_fire[k]) slot_fill[k] <= 1'b1;
            end
            if (|to_fire) timeout_q <= 1'b1;
`endif
        end
    end

    // Beat storage needs no reset: slot_fill gates every read.
    always_ff @(posedge clk) begin
        if (ack_ok) slot_dat[ack_idx] <= resp.dat;
`ifdef VIDEO_FETCH_TIMEOUT_EN
        for (int k = 0; k < NTAG; k++) begin
            if (to_fire[k]) slot_dat[k] <= {4{32'hDEAD_BEEF}};
        end
`endif
    end

endmodule

// File: tb/tb_video_fetch_rbuf.sv
// tb_video_fetch_rbuf: randomized scoreboard bench for video_fetch_rbuf.
// A memory model answers requests out of order with jitter; the monitor checks beats in address order.
// Knobs in the main sequence steer ack delay, stall bursts and consumer readiness.
module tb_video_fetch_rbuf;
    import fta_pkg::*;

    localparam int NTAG = 8;
    localparam int BB   = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 line_start = 1'b0;
    logic [31:0]          base_adr = '0;
    logic [11:0]          nbeats = '0;
    fta_cmd_request128_t  req;
    fta_cmd_response128_t resp;
    logic [127:0]         dat_o;
    logic                 dat_vld;
    logic                 dat_rdy = 1'b0;
    logic                 busy;
    logic                 line_done;
    logic                 overrun;
    logic                 bad_tid;

    always #5 clk = ~clk;

    video_fetch_rbuf #(.NTAG(NTAG), .BEAT_BYTES(BB)) dut (
        .clk        (clk),
        .rst        (rst),
        .line_start (line_start),
        .base_adr   (base_adr),
        .nbeats     (nbeats),
        .req        (req),
        .resp       (resp),
        .dat_o      (dat_o),
        .dat_vld    (dat_vld),
        .dat_rdy    (dat_rdy),
        .busy       (busy),
        .line_done  (line_done),
        .overrun    (overrun),
        .bad_tid    (bad_tid)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] mem_dat(input logic [31:0] a);
        return {a, a ^ 32'hA5A5_5A5A, ~a, a + 32'h1234_5678};
    endfunction

    // ---------------- reference model state ----------------
    logic [127:0] exp_q[$];
    logic [31:0]  adr_q[$];
    int           exp_ld = 0;

    typedef struct {
        logic [7:0]   tid;
        logic [127:0] dat;
        int           dly;
    } pend_t;
    pend_t pend_q[$];

    // knobs
    int         dly_mode = 0;     // 0: fixed dly_fix, 1: random 1..16
    int         dly_fix = 2;
    bit         ack_en = 1'b1;
    bit         stall_en = 1'b0;
    int         rdy_mode = 0;     // 0: always ready, 1: random, 2: never ready
    bit         inj_vld = 1'b0;
    logic [7:0] inj_tid = '0;

    int issued_tot = 0;
    int cons_mem = 0;
    int issued_line = 0;
    int ld_cnt = 0;

    // ---------------- memory responder ----------------
    initial begin
        logic        hold_pend;
        logic [31:0] h_adr;
        logic [7:0]  h_tid;
        int          stall_left;
        int          rdy_idx[$];
        int          k;
        pend_t       p;
        hold_pend  = 1'b0;
        stall_left = 0;
        h_adr      = '0;
        h_tid      = '0;
        resp       = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (hold_pend) begin
                    chk("stall_hold_cyc", req.cyc, 1);
                    chk("stall_hold_adr", req.adr, h_adr);
                    chk("stall_hold_tid", req.tid, h_tid);
                end
                if (dat_vld && dat_rdy) cons_mem++;
                if (req.cyc && !resp.stall) begin
                    if (adr_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_request: got adr %h expected none", req.adr);
                    end else begin
                        chk("req_adr", req.adr, adr_q.pop_front());
                    end
                    chk("req_read", {req.we, req.stb, req.sel}, {1'b0, 1'b1, 16'hFFFF});
                    issued_tot++;
                    issued_line++;
                    chk("outstanding_le_ntag", ((issued_tot - cons_mem) <= NTAG), 1);
                    p.tid = req.tid;
                    p.dat = mem_dat(req.adr);
                    p.dly = (dly_mode == 0) ? dly_fix : int'($urandom_range(1, 16));
                    pend_q.push_back(p);
                end
                hold_pend = req.cyc && resp.stall;
                h_adr     = req.adr;
                h_tid     = req.tid;
            end else begin
                hold_pend = 1'b0;
            end

            @(posedge clk);
            #1;
            for (int i = 0; i < pend_q.size(); i++) pend_q[i].dly = pend_q[i].dly - 1;
            resp.ack = 1'b0;
            resp.tid = '0;
            resp.dat = '0;
            if (inj_vld) begin
                resp.ack = 1'b1;
                resp.tid = inj_tid;
                resp.dat = '1;
                inj_vld  = 1'b0;
            end else if (ack_en) begin
                rdy_idx.delete();
                for (int i = 0; i < pend_q.size(); i++)
                    if (pend_q[i].dly <= 0) rdy_idx.push_back(i);
                if (rdy_idx.size() > 0) begin
                    k = rdy_idx[$urandom_range(0, rdy_idx.size() - 1)];
                    resp.ack = 1'b1;
                    resp.tid = pend_q[k].tid;
                    resp.dat = pend_q[k].dat;
                    pend_q.delete(k);
                end
            end
            if (stall_en) begin
                if (stall_left > 0) begin
                    resp.stall = 1'b1;
                    stall_left--;
                end else if ($urandom_range(0, 3) == 0) begin
                    resp.stall = 1'b1;
                    stall_left = 2;
                end else begin
                    resp.stall = 1'b0;
                end
            end else begin
                resp.stall = 1'b0;
            end
        end
    end

    // ---------------- consumer ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       dat_rdy = 1'b1;
                1:       dat_rdy = 1'($urandom_range(0, 1));
                default: dat_rdy = 1'b0;
            endcase
        end
    end

    // ---------------- output monitor ----------------
    initial begin
        logic [127:0] e;
        forever begin
            @(negedge clk);
            if (rst && dat_vld && dat_rdy) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_beat: got %h expected none", dat_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", dat_o, e);
                end
            end
            if (rst && line_done) ld_cnt++;
        end
    end

    // ---------------- sequence helpers ----------------
    task automatic start_line(input logic [31:0] b, input int n, input bit accept);
        logic [31:0] a;
        @(posedge clk);
        #1;
        line_start = 1'b1;
        base_adr   = b;
        nbeats     = 12'(n);
        if (accept) begin
            exp_ld++;
            issued_line = 0;
            for (int i = 0; i < n; i++) begin
                a = b + 32'(i * BB);
                adr_q.push_back(a);
                exp_q.push_back(mem_dat(a));
            end
        end
        @(posedge clk);
        #1;
        line_start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int c;
        c = 0;
        while (ld_cnt != exp_ld && c < bound) begin
            @(negedge clk);
            #1;
            c++;
        end
        chk("line_done_count", ld_cnt, exp_ld);
    endtask

    task automatic post_line(input string nm);
        repeat (3) @(negedge clk);
        #1;
        chk({nm, "_idle"}, busy, 0);
        chk({nm, "_beats_left"}, exp_q.size(), 0);
        chk({nm, "_reqs_left"}, adr_q.size(), 0);
        chk({nm, "_no_vld"}, dat_vld, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int c;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cyc", req.cyc, 0);
        chk("rst_vld", dat_vld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", line_done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_bad_tid", bad_tid, 0);
        rst = 1'b1;

        // basic 4-beat line, fixed 2-cycle acks
        dly_mode = 0; dly_fix = 2; rdy_mode = 0;
        start_line(32'h0000_1000, 4, 1);
        chk("busy_in_line", busy, 1);
        wait_done(500);
        post_line("basic");

        // zero-length line: done pulse only
        start_line(32'h0000_5000, 0, 1);
        wait_done(20);
        post_line("zero");

        // 20 beats, random jitter, random consumer
        dly_mode = 1; rdy_mode = 1;
        start_line(32'h0002_0000, 20, 1);
        wait_done(3000);
        post_line("jitter");

        // consumer blocked for 50 cycles
        dly_mode = 0; dly_fix = 2; rdy_mode = 2;
        start_line(32'h0000_3000, 20, 1);
        repeat (50) @(negedge clk);
        #1;
        chk("issued_while_blocked", issued_line, NTAG);
        chk("cyc_while_blocked", req.cyc, 0);
        rdy_mode = 0;
        wait_done(2000);
        post_line("blocked");

        // stall bursts
        stall_en = 1'b1; dly_mode = 1; rdy_mode = 1;
        start_line(32'h0000_4000, 24, 1);
        wait_done(4000);
        post_line("stall");
        stall_en = 1'b0;

        // address wrap past 2^32
        start_line(32'hFFFF_FFE0, 4, 1);
        wait_done(500);
        post_line("wrap");

        // stray ack while idle, then a line_start during a line
        rdy_mode = 0; dly_mode = 0;
        inj_tid = 8'd3; inj_vld = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("bad_tid_set", bad_tid, 1);
        chk("overrun_clear", overrun, 0);
        rdy_mode = 1;
        start_line(32'h0000_6000, 10, 1);
        start_line(32'h0000_9000, 5, 0);
        chk("overrun_set", overrun, 1);
        wait_done(2000);
        repeat (30) @(negedge clk);
        #1;
        chk("single_done_after_overrun", ld_cnt, exp_ld);
        post_line("overrun");

        // random lines
        for (int l = 0; l < 6; l++) begin
            stall_en = 1'($urandom_range(0, 1));
            dly_mode = 1; rdy_mode = 1;
            start_line($urandom & 32'hFFFF_FFF0, int'($urandom_range(1, 40)), 1);
            wait_done(5000);
            post_line("rand");
        end
        stall_en = 1'b0;

        // reset with 5 beats outstanding, then late acks
        dly_mode = 0; dly_fix = 1; ack_en = 1'b0; rdy_mode = 2;
        start_line(32'h0000_7000, 12, 1);
        c = 0;
        while (issued_line < 5 && c < 100) begin
            @(negedge clk);
            #1;
            c++;
        end
        chk("five_outstanding", issued_line, 5);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_cyc", req.cyc, 0);
        chk("mid_rst_vld", dat_vld, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", line_done, 0);
        chk("mid_rst_overrun", overrun, 0);
        chk("mid_rst_bad_tid", bad_tid, 0);
        exp_q.delete();
        adr_q.delete();
        exp_ld     = ld_cnt;
        issued_tot = cons_mem;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        rdy_mode = 0;
        ack_en = 1'b1;
        c = 0;
        while (pend_q.size() != 0 && c < 100) begin
            @(negedge clk);
            #1;
            c++;
        end
        chk("late_acks_delivered", pend_q.size(), 0);
        repeat (3) @(negedge clk);
        #1;
        chk("late_ack_bad_tid", bad_tid, 1);
        chk("late_ack_overrun", overrun, 0);
        chk("late_ack_busy", busy, 0);
        chk("late_ack_vld", dat_vld, 0);

        // recovery line after reset
        dly_mode = 1; rdy_mode = 1;
        start_line(32'h0000_8000, 6, 1);
        wait_done(2000);
        post_line("recover");
        chk("bad_tid_sticky", bad_tid, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #800000;
        n_bad++;
        $display("FAIL watchdog: got no end of sequence expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/video_fetch_rbuf.md
VIDEO_FETCH_RBUF -- requirements
Module: video_fetch_rbuf

Interface
REQ-001 SHALL have parameter NTAG, default 8, giving the number of outstanding read slots (power of two, 2..16).
REQ-002 SHALL have parameter BEAT_BYTES, default 16, giving the address increment per 128-bit beat.
REQ-003 SHALL have port clk  input  1  sole clock, all state on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port line_start  input  1  single-cycle pulse requesting one scanline fetch.
REQ-006 SHALL have port base_adr  input  32  byte address of the scanline's first beat, sampled on an accepted line_start.
REQ-007 SHALL have port nbeats  input  12  number of beats in the scanline, sampled with base_adr; 0 means no fetch.
REQ-008 SHALL have port req  output  fta_cmd_request128_t  read request to memory or VideoTPG.
REQ-009 SHALL have port resp  input  fta_cmd_response128_t  memory response; ack, tid, dat, stall used.
REQ-010 SHALL have port dat_o  output  128  in-order beat data.
REQ-011 SHALL have port dat_vld  output  1  dat_o valid.
REQ-012 SHALL have port dat_rdy  input  1  consumer accepts dat_o.
REQ-013 SHALL have port busy / line_done / overrun / bad_tid  outputs  1 each  status; line_done is a pulse, overrun and bad_tid are sticky.

Function
REQ-014 SHALL implement states IDLE, FETCH and DRAIN.
REQ-015 In IDLE, line_start with nbeats!=0 SHALL latch the inputs, clear the issue/retire counters and enter FETCH next cycle; with nbeats==0 it SHALL pulse line_done and stay in IDLE.
REQ-016 line_start outside IDLE SHALL be ignored and SHALL set overrun.
REQ-017 In FETCH a request SHALL issue when the slot at the issue pointer is free: cyc=1, we=0, adr=base+issue_cnt*BEAT_BYTES (32-bit wrap), tid low bits=slot index.
REQ-018 While resp.stall=1, cyc, adr and tid SHALL hold unchanged and the issue pointer SHALL NOT advance.
REQ-019 A slot SHALL be busy from issue until its beat is consumed; at most NTAG beats SHALL be outstanding or buffered.
REQ-020 When issue_cnt reaches nbeats, the block SHALL drop cyc and enter DRAIN.
REQ-021 resp.ack whose tid slot is in flight SHALL store resp.dat in that slot and mark it filled; responses SHALL be accepted in any order.
REQ-022 resp.ack for a slot not in flight SHALL be discarded and SHALL set bad_tid.
REQ-023 dat_vld SHALL be 1 exactly when the head slot is filled, with dat_o = that slot's data; the minimum latency from ack to dat_vld SHALL be 1 cycle.
REQ-024 dat_vld&dat_rdy SHALL free the head slot and advance the head pointer modulo NTAG; the slot SHALL be reissuable in the same cycle.
REQ-025 In the same cycle, ack into slot k and consumption of a different slot SHALL both take effect.
REQ-026 In DRAIN, once the retire count equals nbeats, the block SHALL pulse line_done for 1 cycle and return to IDLE.
REQ-027 busy SHALL be 1 in FETCH and DRAIN.

Reset
REQ-028 Reset SHALL, asynchronously and at any time, force IDLE, all slots free, all pointers and counters 0, cyc=0, dat_vld=0, line_done=0, overrun=0 and bad_tid=0.
REQ-029 Reset SHALL be the only clear for overrun and bad_tid.

Configuration
REQ-030 Macro VIDEO_FETCH_TIMEOUT_EN: when defined, each in-flight slot SHALL have an 8-bit age counter; at 255 cycles without ack the slot SHALL be filled with 128'hDEAD_BEEF repeated and a sticky timeout output SHALL be set.
REQ-031 When VIDEO_FETCH_TIMEOUT_EN is undefined, the counters and the timeout port SHALL be absent and slots SHALL wait indefinitely.

Verification
REQ-032 line_start, base=0x1000, nbeats=4, fixed 2-cycle acks -> adr 0x1000/0x1010/0x1020/0x1030; four dat_o beats in order; one line_done.
REQ-033 NTAG=8, nbeats=20, responses in random jitter order 1..16 cycles -> dat_o strictly in address order; never more than 8 outstanding.
REQ-034 dat_rdy=0 for 50 cycles -> exactly 8 requests issued, then cyc=0 until dat_rdy=1.
REQ-035 Ack with tid of a free slot, then line_start during FETCH -> bad_tid=1 and overrun=1; the line completes unchanged.
REQ-036 resp.stall=1 for 3 cycles -> adr and tid held; no beat dropped or duplicated.
REQ-037 Reset asserted mid-FETCH with 5 beats outstanding, then late acks -> outputs at reset values; late acks set bad_tid only.
